sysreg_access_ctrl: RTL and testbench
=====================================

# sysreg_access_ctrl

Sequencer for the system-register move instructions MTS (GPR → sysreg) and MFS (sysreg → GPR). It sits after instruction decode and does the following:
- accepts one 32-bit opcode at a time;
- checks the opcode and its privilege level;
- reads the source GPR when needed;
- runs a request/acknowledge transaction with a timeout on the system-register file bus;
- writes MFS results back to the GPR file and reports completion or a fault.

Only one instruction is in flight at a time.

## Interface
Parameters:
- XLEN, 32, data width of GPR and sysreg values
- TIMEOUT, 16, maximum BUS-state cycles before a timeout fault (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  opcode offered
- in_ready  out  1  controller can accept (high only in IDLE)
- in_insn  in  32  opcode
- cur_pl  in  2  current privilege level (3 = most privileged)
- gpr_ren  out  1  GPR read strobe
- gpr_raddr  out  5  GPR read address
- gpr_rdata  in  XLEN  GPR data, valid the cycle after gpr_ren
- sr_req  out  1  sysreg bus request
- sr_we  out  1  1 = write (MTS), 0 = read (MFS)
- sr_id  out  10  sysreg id
- sr_wdata  out  XLEN  write data
- sr_ack  in  1  transaction complete
- sr_err  in  1  transaction failed
- sr_rdata  in  XLEN  read data, valid with sr_ack
- wb_valid  out  1  GPR write strobe
- wb_rd  out  5  GPR write address
- wb_data  out  XLEN  GPR write data
- done_valid  out  1  one-cycle retire pulse
- fault  out  1  qualifies done_valid: instruction faulted
- fault_code  out  2  0 illegal opcode, 1 privilege, 2 bus error, 3 timeout
- busy  out  1  state ≠ IDLE

## Operation
Decode (combinational on in_insn, captured at accept):
- MTS: insn[31:23]==0 and insn[7:0]==8'h0D.
- MFS: insn[31:23]==0 and insn[7:0]==8'h0C.
- rd = insn[22:18]; sr_id = insn[17:8].
- Sysreg fields: group = sr_id[4:0], pl = sr_id[6:5], num = sr_id[9:7].
- Any other opcode is illegal.
- Privilege check passes when cur_pl ≥ pl. cur_pl is sampled at accept.

FSM states: IDLE, GPR, BUS, WB, DONE.
- IDLE: in_ready=1. On in_valid, capture opcode, rd, sr_id and cur_pl, then:
  - illegal opcode → DONE with fault_code 0;
  - privilege fail → DONE with fault_code 1;
  - MTS → GPR;
  - MFS → BUS.
- GPR: gpr_ren=1, gpr_raddr=rd for one cycle → BUS. Capture gpr_rdata on the first BUS cycle into the wdata register.
  - sr_wdata is driven from that register in every BUS cycle after the first.
  - In the first BUS cycle, sr_wdata is gpr_rdata passed straight through.
- BUS: sr_req=1. sr_we, sr_id and sr_wdata stay stable until the exit cycle. Priority within a cycle:
  1. sr_err → DONE with fault_code 2;
  2. sr_ack → WB for MFS (capture sr_rdata), DONE for MTS;
  3. the cycle counter reaching TIMEOUT−1 with neither → DONE with fault_code 3;
  4. otherwise increment the counter.
- WB: wb_valid=1, wb_rd=rd, wb_data=captured read data for one cycle → DONE.
- DONE: done_valid=1, with fault and fault_code valid this cycle only → IDLE.
- On a fault there is no GPR write. The sysreg is not written on illegal or privilege faults because sr_req is never raised.

Width rules: the BUS cycle counter is $clog2(TIMEOUT) bits and is cleared on entry to BUS.

## Timing
- Reset: state IDLE. Every output is 0 except in_ready=1. Internal capture registers and the counter are 0.
- Reset mid-transaction returns to IDLE on the next edge. sr_req drops immediately and the abandoned request is discarded. No done_valid is issued for the aborted instruction.
- Accept happens in cycle 0 (in_valid & in_ready).
- Latency to done_valid, with sr_ack in the first BUS cycle:
  - MFS: BUS c1, WB c2, DONE c3.
  - MTS: GPR c1, BUS c2, DONE c3.
  - Illegal or privilege fault: DONE c1.
- Each extra BUS cycle before ack adds one cycle.
- sr_ack arriving in BUS cycle number TIMEOUT (counter = TIMEOUT−1) is honoured. Timeout fires only if that cycle also has no ack or err.
- sr_ack and sr_err together: error wins and read data is dropped.
- sr_ack/sr_err outside BUS are ignored.
- The next instruction is accepted in the cycle after DONE. Back-to-back throughput is therefore 1 instruction per 2 cycles at best (faulting opcodes).

## Test plan
- MFS, insn=32'h0014_010C (rd=5, sr_id=0x001, pl=0), cur_pl=0, sr_ack+sr_rdata=32'hDEAD_BEEF in first BUS cycle → sr_req/sr_we=0/sr_id=0x001 at c1; wb_valid c2 with rd=5, data DEADBEEF; done_valid c3 with fault=0.
- MTS rd=3, sr_id pl=2, cur_pl=3, gpr_rdata=32'h1234_5678, ack after 4 BUS cycles → gpr_ren c1 addr 3; sr_we=1, sr_wdata=12345678 held stable through all 4 BUS cycles; done c6 with fault=0; no wb_valid.
- Privilege: MFS with sr_id pl=3, cur_pl=1 → no sr_req; done_valid c1 with fault=1, fault_code=1.
- Illegal opcode 32'h0000_0001 (NOP) → done_valid c1 with fault_code 0.
- Timeout with TIMEOUT=16 and no ack → sr_req high exactly 16 cycles, then fault_code 3. Repeat with ack in BUS cycle 16 → success. Repeat with ack and err in the same cycle → fault_code 2, no wb_valid.
- Assert rst during BUS → next cycle sr_req=0, in_ready=1, no done_valid; a new MFS then completes normally.

Source files
------------

// File: rtl/sysreg_access_ctrl.sv
// rtl/sysreg_access_ctrl.sv - MTS/MFS system-register move sequencer with bus timeout
module sysreg_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [1:0]      cur_pl,
  output logic            gpr_ren,
  output logic [4:0]      gpr_raddr,
  input  logic [XLEN-1:0] gpr_rdata,
  output logic            sr_req,
  output logic            sr_we,
  output logic [9:0]      sr_id,
  output logic [XLEN-1:0] sr_wdata,
  input  logic            sr_ack,
  input  logic            sr_err,
  input  logic [XLEN-1:0] sr_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            done_valid,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic            busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GPR, S_BUS, S_WB, S_DONE} state_t;

  state_t          state, state_nx;
  logic            is_mts;
  logic [4:0]      rd_q;
  logic [9:0]      sr_id_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [CW-1:0]   cnt;
  logic            fault_q;
  logic [1:0]      code_q;

  logic dec_mts, dec_mfs, dec_legal, dec_priv_ok, bus_first, cnt_last;

  // sr_id privilege field sr_id[6:5] sits at in_insn[14:13]
  assign dec_mts     = (in_insn[31:23] == 9'd0) && (in_insn[7:0] == 8'h0D);
  assign dec_mfs     = (in_insn[31:23] == 9'd0) && (in_insn[7:0] == 8'h0C);
  assign dec_legal   = dec_mts || dec_mfs;
  assign dec_priv_ok = (cur_pl >= in_insn[14:13]);
  assign bus_first   = (state == S_BUS) && (cnt == '0);
  assign cnt_last    = (cnt == CW'(TIMEOUT - 1));
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    gpr_ren    = 1'b0;
    gpr_raddr  = '0;
    sr_req     = 1'b0;
    sr_we      = 1'b0;
    sr_id      = '0;
    sr_wdata   = '0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    done_valid = 1'b0;
    fault      = 1'b0;
    fault_code = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!dec_legal || !dec_priv_ok) state_nx = S_DONE;
          else if (dec_mts)               state_nx = S_GPR;
          else                            state_nx = S_BUS;
        end
      end
      S_GPR: begin
        gpr_ren   = 1'b1;
        gpr_raddr = rd_q;
        state_nx  = S_BUS;
      end
      S_BUS: begin
        sr_req = 1'b1;
        sr_we  = is_mts;
        sr_id  = sr_id_q;
        // GPR data lands the first BUS cycle; pass it through until it is registered
        if (is_mts) sr_wdata = bus_first ? gpr_rdata : wdata_q;
        if (sr_err)                 state_nx = S_DONE;
        else if (sr_ack && !is_mts) state_nx = S_WB;
        else if (sr_ack || cnt_last) state_nx = S_DONE;
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        wb_data  = rdata_q;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        fault      = fault_q;
        fault_code = code_q;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_mts  <= 1'b0;
      rd_q    <= '0;
      sr_id_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
      code_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            is_mts  <= dec_mts;
            rd_q    <= in_insn[22:18];
            sr_id_q <= in_insn[17:8];
            cnt     <= '0;
            fault_q <= !(dec_legal && dec_priv_ok);
            code_q  <= dec_legal ? 2'd1 : 2'd0;
          end
        end
        S_BUS: begin
          if (bus_first && is_mts) wdata_q <= gpr_rdata;
          if (sr_err) begin
            fault_q <= 1'b1;
            code_q  <= 2'd2;
          end else if (sr_ack) begin
            if (!is_mts) rdata_q <= sr_rdata;
          end else if (cnt_last) begin
            fault_q <= 1'b1;
            code_q  <= 2'd3;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysreg_access_ctrl.sv
// tb/tb_sysreg_access_ctrl.sv - table plus randomized checks of sysreg_access_ctrl
module tb_sysreg_access_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [1:0]  cur_pl;
  logic        gpr_ren;
  logic [4:0]  gpr_raddr;
  logic [31:0] gpr_rdata;
  logic        sr_req, sr_we;
  logic [9:0]  sr_id;
  logic [31:0] sr_wdata;
  logic        sr_ack, sr_err;
  logic [31:0] sr_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done_valid, fault;
  logic [1:0]  fault_code;
  logic        busy;

  sysreg_access_ctrl #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .cur_pl(cur_pl), .gpr_ren(gpr_ren), .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
    .sr_req(sr_req), .sr_we(sr_we), .sr_id(sr_id), .sr_wdata(sr_wdata), .sr_ack(sr_ack),
    .sr_err(sr_err), .sr_rdata(sr_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .done_valid(done_valid), .fault(fault), .fault_code(fault_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus fields first, expected results after; ack_at/err_at are 1-based BUS cycles, 0 = never
  typedef struct {
    logic [31:0] insn;
    logic [1:0]  pl;
    logic [31:0] gval;
    int          ack_at;
    int          err_at;
    logic [31:0] rdata;
    int          done_c;
    logic        flt;
    logic [1:0]  code;
    int          bus_n;
    int          wb_n;
    int          gpr_n;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  int          o_done, o_bus, o_bus_bad, o_wb, o_gpr_n, o_gpr_c;
  logic        o_fault;
  logic [1:0]  o_code;
  logic [4:0]  o_wb_rd, o_gpr_addr;
  logic [31:0] o_wb_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t model(input vec_t v);
    logic mts, legal;
    logic [9:0] id;
    int k;
    mts   = (v.insn[31:23] == 9'd0) && (v.insn[7:0] == 8'h0D);
    legal = mts || ((v.insn[31:23] == 9'd0) && (v.insn[7:0] == 8'h0C));
    id    = v.insn[17:8];
    v.flt = 1'b1; v.code = 2'd0; v.bus_n = 0; v.wb_n = 0; v.gpr_n = 0;
    if (!legal) begin
      v.done_c = 1;
    end else if (v.pl < id[6:5]) begin
      v.done_c = 1; v.code = 2'd1;
    end else begin
      k = TIMEOUT;
      for (int i = TIMEOUT; i >= 1; i--) if (v.ack_at == i || v.err_at == i) k = i;
      v.bus_n = k;
      v.gpr_n = mts ? 1 : 0;
      if (v.err_at == k) v.code = 2'd2;
      else if (v.ack_at == k) begin
        v.flt = 1'b0;
        v.wb_n = mts ? 0 : 1;
      end else v.code = 2'd3;
      v.done_c = (mts ? 2 : 1) + k + v.wb_n;
    end
    return v;
  endfunction

  task automatic run(input vec_t v);
    int   bc;
    logic prev_gpr;
    logic mts;
    mts = (v.insn[7:0] == 8'h0D);
    o_done = 0; o_bus = 0; o_bus_bad = 0; o_wb = 0; o_gpr_n = 0; o_gpr_c = 0;
    o_fault = 1'b0; o_code = 2'd0; o_wb_rd = '0; o_wb_data = '0; o_gpr_addr = '0;
    bc = 0; prev_gpr = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_insn = v.insn; cur_pl = v.pl;
    sr_ack = ($urandom & 1) != 0; sr_err = ($urandom & 1) != 0;
    #1;
    chk("accept_ready", in_ready, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_insn  = $urandom;
      cur_pl   = 2'($urandom_range(0, 3));
      gpr_rdata = prev_gpr ? v.gval : $urandom;
      if (sr_req) begin
        bc++;
        sr_ack   = (bc == v.ack_at);
        sr_err   = (bc == v.err_at);
        sr_rdata = sr_ack ? v.rdata : $urandom;
      end else begin
        sr_ack   = ($urandom & 1) != 0;
        sr_err   = ($urandom & 1) != 0;
        sr_rdata = $urandom;
      end
      #1;
      prev_gpr = gpr_ren;
      if (gpr_ren) begin
        o_gpr_n++; o_gpr_c = c; o_gpr_addr = gpr_raddr;
      end
      if (sr_req) begin
        o_bus++;
        if (sr_we !== mts || sr_id !== v.insn[17:8]) o_bus_bad++;
        if (mts && sr_wdata !== v.gval) o_bus_bad++;
      end
      if (wb_valid) begin
        o_wb++; o_wb_rd = wb_rd; o_wb_data = wb_data;
      end
      if (done_valid) begin
        o_done = c; o_fault = fault; o_code = fault_code;
        break;
      end
    end
    sr_ack = 1'b0; sr_err = 1'b0;
  endtask

  task automatic compare(input string tag, input vec_t e);
    chk({tag, ".done_cycle"}, o_done, e.done_c);
    chk({tag, ".fault"}, o_fault, e.flt);
    if (e.flt) chk({tag, ".fault_code"}, o_code, e.code);
    chk({tag, ".bus_cycles"}, o_bus, e.bus_n);
    chk({tag, ".bus_fields"}, o_bus_bad, 0);
    chk({tag, ".wb_count"}, o_wb, e.wb_n);
    if (e.wb_n > 0) begin
      chk({tag, ".wb_data"}, o_wb_data, e.rdata);
      chk({tag, ".wb_rd"}, o_wb_rd, e.insn[22:18]);
    end
    chk({tag, ".gpr_reads"}, o_gpr_n, e.gpr_n);
    if (e.gpr_n > 0) begin
      chk({tag, ".gpr_cycle"}, o_gpr_c, 1);
      chk({tag, ".gpr_addr"}, o_gpr_addr, e.insn[22:18]);
    end
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v;
    int   stray;
    tbl[0] = '{32'h0014_010C, 2'd0, 32'h0,         1,  0, 32'hDEAD_BEEF, 3,  1'b0, 2'd0, 1,  1, 0};
    tbl[1] = '{32'h000C_400D, 2'd3, 32'h1234_5678, 4,  0, 32'h0,         6,  1'b0, 2'd0, 4,  0, 1};
    tbl[2] = '{32'h0004_600C, 2'd1, 32'h0,         1,  0, 32'h0,         1,  1'b1, 2'd1, 0,  0, 0};
    tbl[3] = '{32'h0000_0001, 2'd3, 32'h0,         1,  0, 32'h0,         1,  1'b1, 2'd0, 0,  0, 0};
    tbl[4] = '{32'h0014_010C, 2'd0, 32'h0,         0,  0, 32'h0,         17, 1'b1, 2'd3, 16, 0, 0};
    tbl[5] = '{32'h0014_010C, 2'd0, 32'h0,         16, 0, 32'hCAFE_F00D, 18, 1'b0, 2'd0, 16, 1, 0};
    tbl[6] = '{32'h0014_010C, 2'd0, 32'h0,         5,  5, 32'h1111_2222, 6,  1'b1, 2'd2, 5,  0, 0};
    tbl[7] = '{32'h0080_000D, 2'd3, 32'h0,         1,  0, 32'h0,         1,  1'b1, 2'd0, 0,  0, 0};
    tbl[8] = '{32'h000C_400D, 2'd3, 32'hAAAA_5555, 0,  1, 32'h0,         3,  1'b1, 2'd2, 1,  0, 1};
    tbl[9] = '{32'h000C_400D, 2'd2, 32'h0F0F_0F0F, 1,  0, 32'h0,         3,  1'b0, 2'd0, 1,  0, 1};

    rst = 1'b1; in_valid = 1'b0; in_insn = '0; cur_pl = '0;
    gpr_rdata = '0; sr_ack = 1'b0; sr_err = 1'b0; sr_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {in_ready, busy, sr_req, sr_we, gpr_ren, wb_valid, done_valid, fault},
        8'b1000_0000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i]);
      compare($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset while the request is outstanding: no retire, then a clean MFS
    @(negedge clk);
    in_valid = 1'b1; in_insn = 32'h0014_010C; cur_pl = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_req", sr_req, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort_outputs", {sr_req, in_ready, done_valid}, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_valid || sr_req) stray++;
    end
    chk("rst_no_stray", stray, 0);
    run(tbl[0]);
    compare("after_reset", tbl[0]);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      v.insn = {9'd0, 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)),
                (kind < 4) ? 8'h0C : 8'h0D};
      if (kind == 8) v.insn = $urandom;
      if (kind == 9) v.insn[31:23] = 9'($urandom_range(1, 511));
      v.pl     = 2'($urandom_range(0, 3));
      v.gval   = $urandom;
      v.rdata  = $urandom;
      v.ack_at = $urandom_range(0, TIMEOUT + 2);
      v.err_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TIMEOUT + 2) : 0;
      v = model(v);
      run(v);
      compare($sformatf("rnd%0d", i), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
